if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//  IF-stage fetch sequencer for the SRAM-like instruction port. Owns the fetch PC, issues one
//  request at a time (req/addr_ok/data_ok), and hands {inst, pc} to the ID-stage IR buffer
//  through a valid/allowin slot. Includes a one-entry skid buffer so a return during an ID stall is never lost.
//  Applies branch/exception redirects and discards any response still in flight.
// PARAMETERS
//  RESET_PC  32'hbfc00000  fetch PC after reset; id_pc value while id_valid=0 after reset
//  NOP_INST  32'h00000000  id_inst value when the slot is empty or flushed
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous, active-high reset
//  inst_req       out  1   SRAM-like request valid
//  inst_wr        out  1   tied 0
//  inst_size      out  2   tied 2'b10 (word)
//  inst_addr      out  32  request address = fetch PC
//  inst_addr_ok   in   1   request accepted this cycle
//  inst_data_ok   in   1   read data valid this cycle
//  inst_rdata     in   32  read data
//  redirect       in   1   branch/exception redirect, single-cycle pulse
//  redirect_pc    in   32  new fetch PC when redirect=1
//  id_allowin     in   1   ID accepts the slot this cycle (0 = ID_stall)
//  id_valid       out  1   slot holds a live instruction
//  id_inst        out  32  instruction to ID
//  id_pc          out  32  PC of id_inst
// BEHAVIOUR
//  Reset: state=S_REQ, pc=RESET_PC, discard=0, skid_valid=0, id_valid=0, id_inst=NOP_INST, id_pc=RESET_PC.
//  inst_req=1 only in S_REQ; inst_addr=pc. At most one outstanding request.
//  S_REQ: addr_ok -> S_WAIT, req_pc<=pc, pc<=pc+4 (mod 2^32, wraps ffff_fffc->0).
//  S_WAIT: data_ok & discard -> drop data, discard<=0, S_REQ.
//          data_ok & !discard: slot free or consumed this cycle -> slot<={rdata,req_pc}, S_REQ;
//          else -> skid<={rdata,req_pc}, skid_valid<=1, S_HOLD.
//  S_HOLD: no request; when id_allowin: slot<=skid, skid_valid<=0, S_REQ.
//  Slot: id_allowin & id_valid & no refill -> id_valid<=0, id_inst<=NOP_INST; id_pc holds.
//  Redirect (priority over all the above except rst):
//    pc<=redirect_pc; id_valid<=0, id_inst<=NOP_INST; skid_valid<=0.
//    In S_REQ without addr_ok: stay S_REQ; next cycle inst_addr=redirect_pc.
//    In S_REQ with addr_ok same cycle: -> S_WAIT with discard=1 (that fetch is stale).
//    In S_WAIT: discard<=1 unless data_ok same cycle (then data dropped, -> S_REQ).
//    In S_HOLD: -> S_REQ.
//  data_ok outside S_WAIT is ignored. This includes a stale response after rst mid-transaction.
//  Order guarantee: ID sees instructions in fetch order; no PC is delivered twice or skipped unless redirected.
//  Latency: addr_ok at cycle n, data_ok at cycle m>n -> id_valid=1 at m+1 (slot free case).
//  Throughput: one instruction every 2 cycles minimum (addr_ok, then data_ok, with 1-cycle memory).
// STRUCTURE
//  Shared pkg cpu_pkg: RESET_PC, NOP_INST, INST_SIZE_WORD=2'b10, fetch state enum {S_REQ,S_WAIT,S_HOLD}.
//  Sub-module fetch_skid_buf: 1-entry {inst,pc} buffer with load/drain/flush.
//  All state registered; only inst_req/inst_addr are combinational from state/pc.
// TESTING
//  1 rst 2 cycles, release -> inst_req=1, inst_addr=bfc00000, id_valid=0, id_pc=bfc00000.
//  2 addr_ok@c1, data_ok@c3 rdata=24080001, allowin=1 -> c4: id_valid=1, id_inst=24080001,
//    id_pc=bfc00000; inst_addr=bfc00004.
//  3 allowin=0, two fetches return (bfc00000, bfc00004) -> 2nd in skid, S_HOLD, inst_req=0;
//    allowin=1 twice -> id_pc bfc00000 then bfc00004, then req at bfc00008.
//  4 redirect=1, redirect_pc=80000100 in S_WAIT; data_ok next cycle -> data dropped,
//    id_valid stays 0, next inst_addr=80000100.
//  5 redirect coincident with addr_ok at bfc00008 -> its data_ok discarded; req to target follows.
//  6 rst during S_WAIT, data_ok in first post-reset cycle -> ignored; id_valid=0,
//    inst_addr=bfc00000; pc=fffffffc fetch -> next inst_addr=00000000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the fetch sequencer state encoding.
package cpu_pkg;
    localparam logic [31:0] RESET_PC       = 32'hbfc00000;
    localparam logic [31:0] NOP_INST       = 32'h00000000;
    localparam logic [1:0]  INST_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {inst, pc} holding register that catches a fetch return while ID is stalled.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc
);
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        // Flush wins so a redirect can never leave a stale entry behind.
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            inst_d  = in_inst;
            pc_d    = in_pc;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= 32'h0;
            pc_q    <= 32'h0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign inst  = inst_q;
    assign pc    = pc_q;
endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: one outstanding SRAM-like request, ID slot plus skid entry, redirects.
//   state  | meaning
//   S_REQ  | inst_req high, waiting for addr_ok at pc
//   S_WAIT | request accepted, waiting for data_ok (dropped if discard set)
//   S_HOLD | slot and skid both full, no new request until ID accepts
module if_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_allowin,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         discard_q, discard_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_inst_q, id_inst_d;
    logic [31:0]  id_pc_q, id_pc_d;

    logic         skid_load, skid_drain, skid_flush, skid_valid;
    logic [31:0]  skid_inst, skid_pc;
    logic         slot_free;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .drain   (skid_drain),
        .flush   (skid_flush),
        .in_inst (inst_rdata),
        .in_pc   (req_pc_q),
        .valid   (skid_valid),
        .inst    (skid_inst),
        .pc      (skid_pc)
    );

    assign slot_free = !id_valid_q || id_allowin;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_flush = 1'b0;

        if (id_allowin && id_valid_q) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
        end

        case (state_q)
            S_REQ: begin
                if (inst_addr_ok) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    state_d = S_REQ;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else if (slot_free) begin
                        id_valid_d = 1'b1;
                        id_inst_d  = inst_rdata;
                        id_pc_d    = req_pc_q;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (id_allowin && skid_valid) begin
                    id_valid_d = 1'b1;
                    id_inst_d  = skid_inst;
                    id_pc_d    = skid_pc;
                    skid_drain = 1'b1;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // A request accepted in the redirect cycle is stale: keep the handshake, drop its data.
        if (redirect) begin
            pc_d       = redirect_pc;
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
            id_pc_d    = id_pc_q;
            skid_load  = 1'b0;
            skid_drain = 1'b0;
            skid_flush = 1'b1;
            case (state_q)
                S_REQ:   discard_d = inst_addr_ok;
                S_WAIT: begin
                    discard_d = !inst_data_ok;
                    state_d   = inst_data_ok ? S_REQ : S_WAIT;
                end
                default: begin
                    discard_d = 1'b0;
                    state_d   = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            discard_q  <= 1'b0;
            id_valid_q <= 1'b0;
            id_inst_q  <= NOP_INST;
            id_pc_q    <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
        end
    end

    assign inst_req  = (state_q == S_REQ);
    assign inst_wr   = 1'b0;
    assign inst_size = INST_SIZE_WORD;
    assign inst_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_inst   = id_inst_q;
    assign id_pc     = id_pc_q;
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed scenarios plus a randomized run scored against an in-order fetch-stream model.
module tb_if_fetch_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_allowin, id_valid;
    logic [31:0] id_inst, id_pc;

    always #5 clk = ~clk;

    if_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_allowin   (id_allowin),
        .id_valid     (id_valid),
        .id_inst      (id_inst),
        .id_pc        (id_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pop = 0;
    int          max_q = 0;
    bit          sb_en = 1'b0;
    logic [31:0] fpc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h13579bdf;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        id_allowin   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every ID handshake must deliver the oldest still-live fetch.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (id_valid && id_allowin) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got pc %h, expected no delivery", id_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    n_pop++;
                    check("sb_pc", id_pc, e.pc);
                    check("sb_inst", id_inst, e.inst);
                end
            end else if (!id_valid) begin
                check("sb_empty_nop", id_inst, NOP_INST);
            end
        end
    end

    initial begin
        bit          pending;
        int          lat;
        logic [31:0] out_addr;
        logic        req_s;
        logic [31:0] addr_s;

        // 1: reset state
        do_reset();
        check("rst_req", inst_req, 1);
        check("rst_addr", inst_addr, 32'hbfc00000);
        check("rst_valid", id_valid, 0);
        check("rst_id_pc", id_pc, 32'hbfc00000);
        check("rst_id_inst", id_inst, NOP_INST);
        check("rst_wr_size", {inst_wr, inst_size}, 3'b010);

        // 2: single fetch, slot free
        inst_addr_ok = 1; cyc();
        check("t2_wait_noreq", inst_req, 0);
        inst_addr_ok = 0; cyc();
        inst_data_ok = 1; inst_rdata = 32'h24080001; id_allowin = 1; cyc();
        check("t2_valid", id_valid, 1);
        check("t2_inst", id_inst, 32'h24080001);
        check("t2_pc", id_pc, 32'hbfc00000);
        check("t2_next_addr", inst_addr, 32'hbfc00004);
        check("t2_req", inst_req, 1);

        // 3: ID stalled, second return goes to the skid
        do_reset();
        inst_addr_ok = 1; cyc();
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h11110000; cyc();
        inst_addr_ok = 1; inst_data_ok = 0; cyc();
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h22220004; cyc();
        inst_data_ok = 0;
        check("t3_hold_noreq", inst_req, 0);
        check("t3_slot_pc0", id_pc, 32'hbfc00000);
        check("t3_slot_inst0", id_inst, 32'h11110000);
        cyc();
        check("t3_hold_stays", inst_req, 0);
        id_allowin = 1; cyc();
        check("t3_slot_pc1", id_pc, 32'hbfc00004);
        check("t3_slot_inst1", id_inst, 32'h22220004);
        check("t3_req_after", {31'h0, inst_req}, 1);
        check("t3_addr_after", inst_addr, 32'hbfc00008);
        cyc();
        check("t3_drained", id_valid, 0);
        check("t3_pc_hold", id_pc, 32'hbfc00004);
        id_allowin = 0;

        // 5: redirect coincident with addr_ok at bfc00008
        inst_addr_ok = 1; redirect = 1; redirect_pc = 32'h80000100; cyc();
        check("t5_wait", inst_req, 0);
        inst_addr_ok = 0; redirect = 0; inst_data_ok = 1; inst_rdata = 32'hdeadbeef; cyc();
        inst_data_ok = 0;
        check("t5_dropped", id_valid, 0);
        check("t5_req", inst_req, 1);
        check("t5_addr", inst_addr, 32'h80000100);

        // 4: redirect while waiting, data_ok next cycle
        inst_addr_ok = 1; cyc();
        inst_addr_ok = 0; redirect = 1; redirect_pc = 32'h80000200; cyc();
        redirect = 0; inst_data_ok = 1; inst_rdata = 32'hcafef00d; cyc();
        inst_data_ok = 0;
        check("t4_dropped", id_valid, 0);
        check("t4_addr", inst_addr, 32'h80000200);
        inst_addr_ok = 1; cyc();
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h3c1d0001; id_allowin = 1; cyc();
        inst_data_ok = 0; id_allowin = 0;
        check("t4_target_pc", id_pc, 32'h80000200);
        check("t4_target_inst", id_inst, 32'h3c1d0001);

        // 6: reset mid-transaction, stale data_ok right after; then pc wrap
        inst_addr_ok = 1; cyc();
        inst_addr_ok = 0; rst = 1; cyc(); cyc();
        rst = 0; inst_data_ok = 1; inst_rdata = 32'h0badf00d; cyc();
        inst_data_ok = 0;
        check("t6_stale_valid", id_valid, 0);
        check("t6_stale_inst", id_inst, NOP_INST);
        check("t6_addr", inst_addr, 32'hbfc00000);
        check("t6_req", inst_req, 1);
        redirect = 1; redirect_pc = 32'hfffffffc; cyc();
        redirect = 0;
        check("t6_wrap_start", inst_addr, 32'hfffffffc);
        inst_addr_ok = 1; cyc();
        check("t6_wrap_pc", inst_addr, 32'h00000000);
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h00000021; id_allowin = 1; cyc();
        idle_inputs();
        check("t6_wrap_id_pc", id_pc, 32'hfffffffc);
        check("t6_wrap_valid", id_valid, 1);
        check("t6_wrap_next", inst_addr, 32'h00000000);

        // Randomized run against the in-order stream model
        do_reset();
        exp_q.delete();
        fpc     = RESET_PC;
        pending = 1'b0;
        lat     = 0;
        out_addr = 32'h0;
        sb_en   = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            req_s  = inst_req;
            addr_s = inst_addr;
            idle_inputs();
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hfffffff8 : ($urandom() & 32'hfffffffc);
            id_allowin  = !redirect && ($urandom_range(0, 3) != 0);
            if (pending) begin
                lat--;
                if (lat == 0) begin
                    inst_data_ok = 1'b1;
                    inst_rdata   = mem_word(out_addr);
                    pending      = 1'b0;
                end
            end else if (req_s && $urandom_range(0, 1) == 1) begin
                inst_addr_ok = 1'b1;
                pending      = 1'b1;
                lat          = $urandom_range(1, 3);
                out_addr     = addr_s;
            end else if ($urandom_range(0, 9) == 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = $urandom();
            end
            if (inst_addr_ok && !redirect) begin
                check("sb_fetch_addr", addr_s, fpc);
                exp_q.push_back('{pc: fpc, inst: mem_word(fpc)});
                fpc = fpc + 32'd4;
            end
            if (redirect) begin
                exp_q.delete();
                fpc = redirect_pc;
            end
            if (exp_q.size() > max_q) max_q = exp_q.size();
            cyc();
        end
        idle_inputs();
        sb_en = 1'b0;
        check("sb_progress", {31'h0, n_pop >= 150}, 1);
        check("sb_max_inflight", {31'h0, max_q <= 3}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
